// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester round-robin arbiter and sequencer for the single-port sram
//   clock, reset               : rising-edge clock, synchronous active-high reset
//   req/we/addr/wdata (0, 1)   : requester commands, held stable until ack
//   ack (0, 1)                 : one-cycle pulse, command issued to the sram
//   rvalid/rdata (0, 1)        : one-cycle read-data pulse, read data held until the next pulse
//   mem_enable, mem_readWrite  : sram enable and direction (1=write)
//   mem_address, mem_dataIn    : sram address and write data
//   mem_dataOut                : sram read data
module sram_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_enable,
    output logic              mem_readWrite,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    input  logic [DATA_W-1:0] mem_dataOut
);
    typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;
    state_t     state, state_nx;
    logic       last;
    logic       owner;
    logic [2:0] cnt;
    logic       issue, win, capture;

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_nx;

    // win is only meaningful when issue is set; on a tie the requester not granted last wins
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        capture  = 1'b0;
        win      = (req0 && req1) ? ~last : req1;
        case (state)
            IDLE: begin
                issue    = req0 || req1;
                state_nx = issue ? ACCESS : IDLE;
            end
            ACCESS: begin
                capture  = !mem_readWrite && RD_LAT == 1;
                state_nx = (mem_readWrite || RD_LAT == 1) ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                capture  = cnt == 3'(RD_LAT - 1);
                state_nx = capture ? IDLE : RD_WAIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            rvalid0       <= 1'b0;
            rvalid1       <= 1'b0;
            rdata0        <= '0;
            rdata1        <= '0;
            mem_enable    <= 1'b0;
            mem_readWrite <= 1'b0;
            mem_address   <= '0;
            mem_dataIn    <= '0;
            last          <= 1'b1;
            owner         <= 1'b0;
            cnt           <= '0;
        end else begin
            ack0    <= issue && !win;
            ack1    <= issue && win;
            rvalid0 <= capture && !owner;
            rvalid1 <= capture && owner;
            if (capture && !owner) rdata0 <= mem_dataOut;
            if (capture && owner) rdata1 <= mem_dataOut;
            if (issue) begin
                last          <= win;
                owner         <= win;
                mem_enable    <= 1'b1;
                mem_readWrite <= win ? we1 : we0;
                mem_address   <= win ? addr1 : addr0;
                mem_dataIn    <= win ? wdata1 : wdata0;
            end else if (state_nx == IDLE) begin
                // sram port is parked at zero whenever the arbiter is idle
                mem_enable    <= 1'b0;
                mem_readWrite <= 1'b0;
                mem_address   <= '0;
                mem_dataIn    <= '0;
            end
            cnt <= (state == ACCESS) ? 3'd1 : (state == RD_WAIT) ? cnt + 3'd1 : 3'd0;
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter against a transaction-level model
module tb_sram_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              ack0, ack1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              mem_enable, mem_readWrite;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_dataIn, mem_dataOut;

    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [0:7];
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    always @(posedge clock)
        if (mem_enable && mem_readWrite) sram[mem_address] <= mem_dataIn;
    assign mem_dataOut = (mem_enable && !mem_readWrite) ? sram[mem_address] : 32'h5A5A_A5A5;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_enable(mem_enable), .mem_readWrite(mem_readWrite),
        .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * RD_LAT + 8; i++) begin
            step();
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({ack0, ack1, rvalid0, rvalid1, mem_enable, mem_readWrite} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 000000", {ack0, ack1, rvalid0, rvalid1, mem_enable, mem_readWrite});
        end
        total++;
        if ({mem_address, mem_dataIn, rdata0, rdata1} !== '0) begin
            bad++;
            $display("FAIL reset_data: addr %h din %h rd0 %h rd1 %h expected all 0", mem_address, mem_dataIn, rdata0, rdata1);
        end
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0010; wdata0 = 32'hDEADBEEF;
        step();
        req0 = 1'b0;
        total++;
        if ({ack0, ack1, mem_enable, mem_readWrite, mem_address, mem_dataIn} !== {4'b1011, 15'h0010, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL wr_issue: got ack %b%b en %b rw %b a %h d %h expected 1 0 1 1 0010 deadbeef",
                     ack0, ack1, mem_enable, mem_readWrite, mem_address, mem_dataIn);
        end
        step();
        total++;
        if ({ack0, mem_enable} !== 2'b00) begin
            bad++;
            $display("FAIL wr_end: got ack0 %b en %b expected 0 0", ack0, mem_enable);
        end
        req0 = 1'b1; we0 = 1'b0;
        step();
        req0 = 1'b0;
        total++;
        if ({ack0, mem_enable, mem_readWrite} !== 3'b110) begin
            bad++;
            $display("FAIL rd_issue: got ack0 %b en %b rw %b expected 1 1 0", ack0, mem_enable, mem_readWrite);
        end
        for (int i = 1; i <= RD_LAT; i++) begin
            step();
            total++;
            if ({rvalid0, mem_enable} !== {i == RD_LAT, i < RD_LAT}) begin
                bad++;
                $display("FAIL rd_timing[%0d]: got rvalid0 %b en %b expected %b %b", i, rvalid0, mem_enable, i == RD_LAT, i < RD_LAT);
            end
        end
        total++;
        if (rdata0 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd_data: got %h expected deadbeef", rdata0);
        end
        step();
    endtask

    task automatic test_tie_reads();
        int a0 = -1, a1 = -1, v0 = -1, v1 = -1;
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0011;
        for (int c = 1; c <= 2 * RD_LAT + 4; c++) begin
            step();
            total++;
            if (ack0 && ack1) begin
                bad++;
                $display("FAIL tie_both_ack[%0d]: got ack0 1 ack1 1 expected at most one", c);
            end
            if (ack0 && a0 < 0) a0 = c;
            if (ack1 && a1 < 0) a1 = c;
            if (rvalid0 && v0 < 0) v0 = c;
            if (rvalid1 && v1 < 0) v1 = c;
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        total++;
        if ({a0, v0, a1, v1} !== {32'd1, 32'(1 + RD_LAT), 32'(2 + RD_LAT), 32'(2 + 2 * RD_LAT)}) begin
            bad++;
            $display("FAIL tie_order: got ack0@%0d rv0@%0d ack1@%0d rv1@%0d expected %0d %0d %0d %0d",
                     a0, v0, a1, v1, 1, 1 + RD_LAT, 2 + RD_LAT, 2 + 2 * RD_LAT);
        end
        total++;
        if ({rdata0, rdata1} !== {32'hDEADBEEF, 32'h12345678}) begin
            bad++;
            $display("FAIL tie_data: got %h %h expected deadbeef 12345678", rdata0, rdata1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_alternating_writes();
        logic [2:0] e;
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0020; wdata0 = 32'h000000A0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 15'h0021; wdata1 = 32'h000000B1;
        for (int i = 1; i <= 12; i++) begin
            step();
            e[2] = (i % 2 == 1) && ((i - 1) / 2) % 2 == 0;
            e[1] = (i % 2 == 1) && ((i - 1) / 2) % 2 == 1;
            e[0] = i % 2 == 1;
            total++;
            if ({ack0, ack1, mem_enable} !== e) begin
                bad++;
                $display("FAIL alt_wr[%0d]: got ack0/ack1/en %b expected %b", i, {ack0, ack1, mem_enable}, e);
            end
            if (i == 11) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        we0 = 1'b0;
        we1 = 1'b0;
        drain();
    endtask

    task automatic test_max_addr_read();
        do_reset();
        req1 = 1'b1; we1 = 1'b0; addr1 = 15'h7FFF;
        step();
        req1 = 1'b0;
        total++;
        if ({ack1, ack0, mem_enable, mem_address} !== {3'b101, 15'h7FFF}) begin
            bad++;
            $display("FAIL max_issue: got ack1 %b ack0 %b en %b a %h expected 1 0 1 7fff", ack1, ack0, mem_enable, mem_address);
        end
        step();
        total++;
        if ({rvalid1, mem_enable, mem_address} !== {2'b01, 15'h7FFF}) begin
            bad++;
            $display("FAIL max_hold: got rvalid1 %b en %b a %h expected 0 1 7fff", rvalid1, mem_enable, mem_address);
        end
        step();
        total++;
        if ({rvalid1, rvalid0, mem_enable, rdata1} !== {3'b100, 32'hCAFEF00D}) begin
            bad++;
            $display("FAIL max_result: got rvalid1 %b rvalid0 %b en %b rd1 %h expected 1 0 0 cafef00d",
                     rvalid1, rvalid0, mem_enable, rdata1);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0010;
        step();
        req0 = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({ack0, ack1, rvalid0, rvalid1, mem_enable, mem_readWrite, mem_address, mem_dataIn, rdata0, rdata1} !== '0) begin
            bad++;
            $display("FAIL midrst_out: got rv0 %b en %b a %h rd0 %h expected all 0", rvalid0, mem_enable, mem_address, rdata0);
        end
        for (int i = 0; i < RD_LAT + 1; i++) begin
            step();
            total++;
            if ({rvalid0, mem_enable} !== 2'b00) begin
                bad++;
                $display("FAIL midrst_quiet[%0d]: got rvalid0 %b en %b expected 0 0", i, rvalid0, mem_enable);
            end
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0011;
        step();
        total++;
        if ({ack0, ack1} !== 2'b10) begin
            bad++;
            $display("FAIL midrst_tie: got ack0/ack1 %b expected 10", {ack0, ack1});
        end
        req0 = 1'b0;
        drain();
    endtask

    task automatic test_req_during_read();
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0010;
        step();
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 15'h7FFF;
        total++;
        if (ack0 !== 1'b1) begin
            bad++;
            $display("FAIL busy_ack0: got %b expected 1", ack0);
        end
        for (int i = 1; i <= RD_LAT; i++) begin
            step();
            total++;
            if ({ack1, rvalid0} !== {1'b0, i == RD_LAT} || (i < RD_LAT && mem_address !== 15'h0010)) begin
                bad++;
                $display("FAIL busy_hold[%0d]: got ack1 %b rv0 %b a %h expected 0 %b 0010", i, ack1, rvalid0, mem_address, i == RD_LAT);
            end
        end
        step();
        req1 = 1'b0;
        total++;
        if ({ack1, mem_address} !== {1'b1, 15'h7FFF}) begin
            bad++;
            $display("FAIL busy_ack1: got ack1 %b a %h expected 1 7fff", ack1, mem_address);
        end
        drain();
    endtask

    // Model works per transaction: an idle arbiter decides at an edge, a write frees it two edges
    // later and a read returns data RD_LAT edges later and frees it one edge after that.
    task automatic test_random();
        logic last_m = 1'b1;
        int next_s = 0;
        int rv_at = -1;
        logic rv_who = 1'b0;
        logic [31:0] rv_data = '0;
        logic w;
        logic [3:0] e;
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            e = 4'b0;
            if (c == next_s) begin
                if (req0 || req1) begin
                    w = (req0 && req1) ? !last_m : !req0;
                    last_m = w;
                    e[3 - w] = 1'b1;
                    if (w ? we1 : we0) begin
                        ref_mem[w ? addr1[2:0] : addr0[2:0]] = w ? wdata1 : wdata0;
                        next_s = c + 2;
                    end else begin
                        rv_at = c + RD_LAT;
                        rv_who = w;
                        rv_data = ref_mem[w ? addr1[2:0] : addr0[2:0]];
                        next_s = c + RD_LAT + 1;
                    end
                end else begin
                    next_s = c + 1;
                end
            end
            if (c == rv_at) e[1 - rv_who] = 1'b1;
            step();
            total++;
            if ({ack0, ack1, rvalid0, rvalid1} !== e) begin
                bad++;
                $display("FAIL rand_ctrl[%0d]: got ack0/ack1/rv0/rv1 %b expected %b", c, {ack0, ack1, rvalid0, rvalid1}, e);
            end
            if (c == rv_at) begin
                total++;
                if ((rv_who ? rdata1 : rdata0) !== rv_data) begin
                    bad++;
                    $display("FAIL rand_data[%0d]: got %h expected %h", c, rv_who ? rdata1 : rdata0, rv_data);
                end
            end
            if (e[3]) req0 = 1'b0;
            if (e[2]) req1 = 1'b0;
            if (!req0 && c < 560 && $urandom_range(2) == 0) begin
                req0 = 1'b1; we0 = 1'($urandom_range(1)); addr0 = 15'h0100 + 15'($urandom_range(7)); wdata0 = $urandom;
            end
            if (!req1 && c < 560 && $urandom_range(2) == 0) begin
                req1 = 1'b1; we1 = 1'($urandom_range(1)); addr1 = 15'h0100 + 15'($urandom_range(7)); wdata1 = $urandom;
            end
        end
        total++;
        if ({req0, req1} !== 2'b00) begin
            bad++;
            $display("FAIL rand_drain: got pending req0/req1 %b expected 00", {req0, req1});
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = '0;
        sram[15'h7FFF] = 32'hCAFEF00D;
        sram[15'h0011] = 32'h12345678;
        test_reset();
        test_write_read();
        test_tie_reads();
        test_alternating_writes();
        test_max_addr_read();
        test_reset_mid_read();
        test_req_during_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
